// File: rtl/data_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_initiator
// Purpose  : Converts one core load/store request into a single
//            CYC/STB/WE/SEL bus transaction. It handles byte-lane steering,
//            load sign/zero extension, misalignment rejection and an ACK
//            timeout.
// Ports    : CLK_I, RST_I        - clock, asynchronous active-high reset
//            rd_en, wr_en        - load / store request (store wins)
//            addr, size          - byte address, log2 access size in bytes
//            unsigned_load       - zero-extend (1) or sign-extend (0) loads
//            wr_data             - right-aligned store data
//            rd_data             - extended load result, held until next load
//            busy, done          - in-flight flag, one-cycle completion pulse
//            misaligned          - completion status pulse, sent with done
//            bus_error           - completion status pulse, sent with done
//            CYC_O, STB_O, WE_O  - bus cycle controls
//            SEL_O, ADR_O, DAT_O - lane selects, aligned address, write data
//            DAT_I, ACK_I        - responder read data and acknowledge
// Revision : 1.0 - initial release
// ============================================================================
module data_bus_initiator #(
    parameter int ADDR_SIZE      = 64,
    parameter int DATA_SIZE      = 64,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [1:0]           size,
    input  logic                 unsigned_load,
    input  logic [DATA_SIZE-1:0] wr_data,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 misaligned,
    output logic                 bus_error,
    output logic                 CYC_O,
    output logic                 STB_O,
    output logic                 WE_O,
    output logic [7:0]           SEL_O,
    output logic [ADDR_SIZE-1:0] ADR_O,
    output logic [DATA_SIZE-1:0] DAT_O,
    input  logic [DATA_SIZE-1:0] DAT_I,
    input  logic                 ACK_I
);

    // The counter only has to reach TIMEOUT_CYCLES-1; the abort happens on
    // the following un-acknowledged edge.
    localparam int CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST_I);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   cyc_q, cyc_d;
    logic                   we_q, we_d;
    logic [7:0]             sel_q, sel_d;
    logic [ADDR_SIZE-1:0]   adr_q, adr_d;
    logic [DATA_SIZE-1:0]   dat_o_q, dat_o_d;
    logic [DATA_SIZE-1:0]   rd_data_q, rd_data_d;
    logic [2:0]             off_q, off_d;
    logic [1:0]             size_q, size_d;
    logic                   uns_q, uns_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   mis_q, mis_d;
    logic                   berr_q, berr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   w_req;
    logic                   w_misalign;
    logic [7:0]             w_sel_base;
    logic [DATA_SIZE-1:0]   w_shifted;
    logic [DATA_SIZE-1:0]   w_load;
    logic                   w_timeout_hit;

    assign w_req = rd_en | wr_en;

    // Access is misaligned when the byte offset is not a multiple of the
    // access size.
    always_comb begin
        w_misalign = 1'b0;
        w_sel_base = 8'h01;
        case (size)
            2'd0: begin w_misalign = 1'b0;        w_sel_base = 8'h01; end
            2'd1: begin w_misalign = addr[0];     w_sel_base = 8'h03; end
            2'd2: begin w_misalign = |addr[1:0];  w_sel_base = 8'h0F; end
            default: begin w_misalign = |addr[2:0]; w_sel_base = 8'hFF; end
        endcase
    end

    // Move the addressed lanes down to bit 0, then extend to the full width.
    always_comb begin
        w_shifted = DAT_I >> {off_q, 3'b000};
        w_load    = w_shifted;
        case (size_q)
            2'd0: w_load = uns_q ? {{(DATA_SIZE-8){1'b0}},  w_shifted[7:0]}
                                 : {{(DATA_SIZE-8){w_shifted[7]}},  w_shifted[7:0]};
            2'd1: w_load = uns_q ? {{(DATA_SIZE-16){1'b0}}, w_shifted[15:0]}
                                 : {{(DATA_SIZE-16){w_shifted[15]}}, w_shifted[15:0]};
            2'd2: w_load = uns_q ? {{(DATA_SIZE-32){1'b0}}, w_shifted[31:0]}
                                 : {{(DATA_SIZE-32){w_shifted[31]}}, w_shifted[31:0]};
            default: w_load = w_shifted;
        endcase
    end

    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_o_d   = dat_o_q;
        rd_data_d = rd_data_q;
        off_d     = off_q;
        size_d    = size_q;
        uns_d     = uns_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        mis_d     = 1'b0;
        berr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    off_d  = addr[2:0];
                    size_d = size;
                    uns_d  = unsigned_load;
                    if (w_misalign) begin
                        // Rejected locally: no bus cycle, report on the next cycle.
                        we_d    = 1'b0;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        we_d    = wr_en;
                        adr_d   = {addr[ADDR_SIZE-1:3], 3'b000};
                        sel_d   = w_sel_base << addr[2:0];
                        dat_o_d = wr_data << {addr[2:0], 3'b000};
                        cyc_d   = 1'b1;
                        busy_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (ACK_I) begin
                    // ACK takes priority over a simultaneous timeout.
                    if (!we_q) begin
                        rd_data_d = w_load;
                    end
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_RESP;
                end else if (w_timeout_hit) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    berr_d  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q   <= ST_IDLE;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_o_q   <= '0;
            rd_data_q <= '0;
            off_q     <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_o_q   <= dat_o_d;
            rd_data_q <= rd_data_d;
            off_q     <= off_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mis_q     <= mis_d;
            berr_q    <= berr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign CYC_O      = cyc_q;
    assign STB_O      = cyc_q;
    assign WE_O       = we_q;
    assign SEL_O      = sel_q;
    assign ADR_O      = adr_q;
    assign DAT_O      = dat_o_q;
    assign rd_data    = rd_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign misaligned = mis_q;
    assign bus_error  = berr_q;

endmodule
`default_nettype wire

// File: tb/tb_data_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_bus_initiator
// Purpose  : Self-checking bench for data_bus_initiator. It drives directed
//            and random load/store requests and checks the results against
//            an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_bus_initiator;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic        rd_en, wr_en;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        unsigned_load;
    logic [63:0] wr_data;
    logic [63:0] rd_data;
    logic        busy, done, misaligned, bus_error;
    logic        CYC_O, STB_O, WE_O;
    logic [7:0]  SEL_O;
    logic [63:0] ADR_O, DAT_O, DAT_I;
    logic        ACK_I;

    int vectors    = 0;
    int miscompares = 0;
    logic [63:0] exp_rd;

    always #5 CLK_I = ~CLK_I;

    data_bus_initiator #(
        .ADDR_SIZE(64), .DATA_SIZE(64), .TIMEOUT_CYCLES(4)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .rd_en(rd_en), .wr_en(wr_en),
        .addr(addr), .size(size), .unsigned_load(unsigned_load),
        .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .done(done),
        .misaligned(misaligned), .bus_error(bus_error), .CYC_O(CYC_O),
        .STB_O(STB_O), .WE_O(WE_O), .SEL_O(SEL_O), .ADR_O(ADR_O),
        .DAT_O(DAT_O), .DAT_I(DAT_I), .ACK_I(ACK_I)
    );

    // ---------------- reference model ----------------
    function automatic logic m_misaligned(input logic [63:0] a, input logic [1:0] sz);
        int o;
        o = int'(a[2:0]);
        return (o % (1 << sz)) != 0;
    endfunction

    function automatic logic [7:0] m_sel(input logic [63:0] a, input logic [1:0] sz);
        int n;
        int m;
        n = 1 << sz;
        m = ((1 << n) - 1) << a[2:0];
        return m[7:0];
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] d, input logic [63:0] a,
                                           input logic [1:0] sz, input logic uns);
        int bits;
        logic [63:0] v;
        logic [63:0] mask;
        bits = 8 << sz;
        v = d >> (8 * a[2:0]);
        if (bits == 64) return v;
        mask = (64'd1 << bits) - 64'd1;
        v = v & mask;
        if (!uns && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    // One full request. Starts and ends 1 time unit after a rising edge.
    task automatic run_txn(input string name, input logic is_wr, input logic [63:0] a,
                           input logic [1:0] sz, input logic uns, input logic [63:0] wd,
                           input logic [63:0] rdat, input int delay);
        rd_en = !is_wr; wr_en = is_wr; addr = a; size = sz;
        unsigned_load = uns; wr_data = wd;
        @(posedge CLK_I); #1;
        if (m_misaligned(a, sz)) begin
            vectors++;
            if ({CYC_O, STB_O, busy, done, misaligned, bus_error} !== 6'b000110) begin
                miscompares++;
                $display("FAIL %s mis_flags got=%b exp=000110", name,
                         {CYC_O, STB_O, busy, done, misaligned, bus_error});
            end
            vectors++;
            if (rd_data !== exp_rd) begin
                miscompares++;
                $display("FAIL %s mis_rd_hold got=%h exp=%h", name, rd_data, exp_rd);
            end
            rd_en = 1'b0; wr_en = 1'b0;
            @(posedge CLK_I); #1;
            vectors++;
            if ({done, misaligned} !== 2'b00) begin
                miscompares++;
                $display("FAIL %s mis_pulse got=%b exp=00", name, {done, misaligned});
            end
            return;
        end
        vectors++;
        if ({CYC_O, STB_O, WE_O, busy, done} !== {1'b1, 1'b1, is_wr, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL %s start_ctl got=%b exp=%b", name,
                     {CYC_O, STB_O, WE_O, busy, done}, {1'b1, 1'b1, is_wr, 1'b1, 1'b0});
        end
        vectors++;
        if (ADR_O !== {a[63:3], 3'b000}) begin
            miscompares++;
            $display("FAIL %s adr got=%h exp=%h", name, ADR_O, {a[63:3], 3'b000});
        end
        vectors++;
        if (SEL_O !== m_sel(a, sz)) begin
            miscompares++;
            $display("FAIL %s sel got=%h exp=%h", name, SEL_O, m_sel(a, sz));
        end
        if (is_wr) begin
            vectors++;
            if (DAT_O !== (wd << (8 * a[2:0]))) begin
                miscompares++;
                $display("FAIL %s dat_o got=%h exp=%h", name, DAT_O, wd << (8 * a[2:0]));
            end
        end
        for (int i = 0; i < delay; i++) begin
            @(posedge CLK_I); #1;
            vectors++;
            if ({CYC_O, done, busy, SEL_O} !== {3'b101, m_sel(a, sz)}) begin
                miscompares++;
                $display("FAIL %s wait_hold got=%b exp=%b", name,
                         {CYC_O, done, busy, SEL_O}, {3'b101, m_sel(a, sz)});
            end
        end
        ACK_I = 1'b1; DAT_I = rdat;
        @(posedge CLK_I); #1;
        ACK_I = 1'b0; DAT_I = {$urandom, $urandom};
        rd_en = 1'b0; wr_en = 1'b0;
        if (!is_wr) exp_rd = m_load(rdat, a, sz, uns);
        vectors++;
        if ({CYC_O, STB_O, WE_O, busy, done, misaligned, bus_error} !== 7'b0000100) begin
            miscompares++;
            $display("FAIL %s resp_flags got=%b exp=0000100", name,
                     {CYC_O, STB_O, WE_O, busy, done, misaligned, bus_error});
        end
        if (!is_wr) begin
            vectors++;
            if (rd_data !== exp_rd) begin
                miscompares++;
                $display("FAIL %s rd_data got=%h exp=%h", name, rd_data, exp_rd);
            end
        end
        @(posedge CLK_I); #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_pulse got=%b exp=0", name, done);
        end
        if (!is_wr) begin
            vectors++;
            if (rd_data !== exp_rd) begin
                miscompares++;
                $display("FAIL %s rd_hold got=%h exp=%h", name, rd_data, exp_rd);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST_I = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; size = '0;
        unsigned_load = 1'b0; wr_data = '0; DAT_I = '0; ACK_I = 1'b0;
        exp_rd = '0;
        #12;
        vectors++;
        if ({CYC_O, STB_O, WE_O, busy, done, misaligned, bus_error, SEL_O, ADR_O, DAT_O, rd_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b/%h/%h/%h/%h exp=all zero",
                     {CYC_O, STB_O, WE_O, busy, done, misaligned, bus_error}, SEL_O, ADR_O, DAT_O, rd_data);
        end
        @(negedge CLK_I); RST_I = 1'b0;
        @(posedge CLK_I); #1;
    endtask

    task automatic test_aligned_load();
        run_txn("aligned_load", 1'b0, 64'h0100_0008, 2'd3, 1'b0, 64'h0,
                64'h1122334455667788, 2);
    endtask

    task automatic test_byte_load();
        run_txn("byte_load_s", 1'b0, 64'h0100_0005, 2'd0, 1'b0, 64'h0,
                64'h0000_8000_0000_0000, 1);
        run_txn("byte_load_u", 1'b0, 64'h0100_0005, 2'd0, 1'b1, 64'h0,
                64'h0000_8000_0000_0000, 0);
    endtask

    task automatic test_half_store();
        run_txn("half_store", 1'b1, 64'h0100_0006, 2'd1, 1'b0, 64'hABCD,
                64'h0, 1);
    endtask

    task automatic test_misaligned();
        run_txn("misaligned", 1'b0, 64'h0100_0002, 2'd2, 1'b0, 64'h0, 64'h0, 0);
    endtask

    // The request is held through the response cycle; it must be ignored
    // there and only be accepted again on the following edge.
    task automatic test_resp_ignore();
        rd_en = 1'b1; wr_en = 1'b0; addr = 64'h0100_0003; size = 2'd1;
        @(posedge CLK_I); #1;
        @(posedge CLK_I); #1;
        vectors++;
        if ({done, misaligned} !== 2'b00) begin
            miscompares++;
            $display("FAIL resp_ignore got=%b exp=00", {done, misaligned});
        end
        @(posedge CLK_I); #1;
        rd_en = 1'b0;
        vectors++;
        if ({done, misaligned} !== 2'b11) begin
            miscompares++;
            $display("FAIL resp_reaccept got=%b exp=11", {done, misaligned});
        end
        @(posedge CLK_I); #1;
    endtask

    task automatic test_timeout();
        rd_en = 1'b1; wr_en = 1'b0; addr = 64'h0100_0010; size = 2'd3;
        unsigned_load = 1'b0;
        @(posedge CLK_I); #1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK_I); #1;
            vectors++;
            if ({CYC_O, done, bus_error} !== 3'b100) begin
                miscompares++;
                $display("FAIL timeout_wait%0d got=%b exp=100", i, {CYC_O, done, bus_error});
            end
        end
        @(posedge CLK_I); #1;
        rd_en = 1'b0;
        vectors++;
        if ({CYC_O, STB_O, busy, done, bus_error, misaligned} !== 6'b000110) begin
            miscompares++;
            $display("FAIL timeout_abort got=%b exp=000110",
                     {CYC_O, STB_O, busy, done, bus_error, misaligned});
        end
        vectors++;
        if (rd_data !== exp_rd) begin
            miscompares++;
            $display("FAIL timeout_rd_hold got=%h exp=%h", rd_data, exp_rd);
        end
        @(posedge CLK_I); #1;
        vectors++;
        if ({done, bus_error} !== 2'b00) begin
            miscompares++;
            $display("FAIL timeout_pulse got=%b exp=00", {done, bus_error});
        end
        // ACK on the edge where the timeout would fire: ACK wins.
        run_txn("ack_on_last", 1'b0, 64'h0100_0018, 2'd2, 1'b1, 64'h0,
                64'hDEAD_BEEF_8765_4321, 3);
    endtask

    task automatic test_reset_mid_wait();
        rd_en = 1'b1; wr_en = 1'b0; addr = 64'h0100_0020; size = 2'd3;
        @(posedge CLK_I); #1;
        vectors++;
        if (CYC_O !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_pre got=%b exp=1", CYC_O);
        end
        #2 RST_I = 1'b1;
        #1;
        rd_en = 1'b0;
        exp_rd = '0;
        vectors++;
        if ({CYC_O, STB_O, busy, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_mid_async got=%b exp=0000", {CYC_O, STB_O, busy, done});
        end
        #2 RST_I = 1'b0;
        @(posedge CLK_I); #1;
        ACK_I = 1'b1;
        @(posedge CLK_I); #1;
        ACK_I = 1'b0;
        vectors++;
        if ({done, CYC_O, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_stray_ack got=%b exp=000", {done, CYC_O, busy});
        end
        @(posedge CLK_I); #1;
        vectors++;
        if ({done, rd_data} !== {1'b0, 64'h0}) begin
            miscompares++;
            $display("FAIL rst_stray_ack2 got=%b/%h exp=0/0", done, rd_data);
        end
        run_txn("after_reset", 1'b0, 64'h0100_0028, 2'd3, 1'b0, 64'h0,
                64'h0123_4567_89AB_CDEF, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [63:0] a;
            logic [1:0]  sz;
            logic        wr;
            a  = {$urandom, $urandom};
            sz = 2'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            run_txn("random", wr, a, sz, 1'($urandom_range(0, 1)),
                    {$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_st", 1'b1, 64'h0100_0004, 2'd2, 1'b0, 64'h1234_5678, 64'h0, 0);
        run_txn("b2b_ld", 1'b0, 64'h0100_0004, 2'd2, 1'b0, 64'h0,
                64'h8000_0001_0000_0000, 0);
        run_txn("b2b_ld2", 1'b0, 64'h0100_0001, 2'd0, 1'b0, 64'h0,
                64'h0000_0000_0000_7F00, 0);
    endtask

    initial begin
        test_reset();
        test_aligned_load();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_resp_ignore();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_bus_initiator.md
Name: data_bus_initiator

Overview:
- Bus initiator on the processor data path: turns a single core load/store request into one CYC/STB/WE/SEL transaction toward the memory controller's responder port.
- Handles byte-lane steering, SEL_O generation, load sign/zero extension, misalignment detection and an ACK timeout.
- Sits between the core's memory stage and the memory controller. Serves ROM (read-only) and RAM (read/write) regions.

Parameters:
- ADDR_SIZE, 64, width of core and bus addresses.
- DATA_SIZE, 64, bus data width in bits (8 byte lanes).
- TIMEOUT_CYCLES, 64, wait cycles before a transaction is aborted; 0 disables the timeout.

Ports:
- CLK_I  in  1  clock; all state changes on the rising edge.
- RST_I  in  1  reset, asynchronous, active-high.
- rd_en  in  1  load request, sampled only in IDLE.
- wr_en  in  1  store request, sampled only in IDLE; wins over rd_en.
- addr  in  ADDR_SIZE  byte address.
- size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- unsigned_load  in  1  1 = zero-extend the load, 0 = sign-extend.
- wr_data  in  DATA_SIZE  store data, right-aligned.
- rd_data  out  DATA_SIZE  extended load result; valid while done is high, held until the next load completes.
- busy  out  1  a transaction is in flight.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  one-cycle pulse with done; no bus cycle was issued.
- bus_error  out  1  one-cycle pulse with done on timeout.
- CYC_O  out  1  bus cycle.
- STB_O  out  1  strobe; equal to CYC_O.
- WE_O  out  1  write enable.
- SEL_O  out  8  byte-lane select.
- ADR_O  out  ADDR_SIZE  8-byte-aligned address.
- DAT_O  out  DATA_SIZE  lane-steered store data.
- DAT_I  in  DATA_SIZE  read data from the responder.
- ACK_I  in  1  responder acknowledge.

Behaviour:
- Reset (asynchronous, effective immediately):
  - Outputs: CYC_O, STB_O, WE_O, busy, done, misaligned and bus_error = 0; SEL_O, ADR_O, DAT_O and rd_data = 0.
  - State = IDLE; timeout counter = 0.
  - Reset during WAIT drops CYC_O at once. The core must reissue the request.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Edge with rd_en or wr_en high: latch addr[2:0], size and unsigned_load. Set WE_O = wr_en.
  - Misaligned request (addr[2:0] mod 2^size != 0): go to RESP with misaligned = 1. No bus cycle is issued.
  - Aligned request: drive the bus outputs, set CYC_O = STB_O = 1 and busy = 1, go to WAIT.
- Bus output computation:
  - ADR_O = addr with bits [2:0] cleared.
  - SEL_O = ((1 << 2^size) - 1) << addr[2:0].
  - DAT_O = wr_data << (8 * addr[2:0]); excess upper bits dropped.
- WAIT:
  - Bus outputs are stable for the whole state.
  - Edge with ACK_I = 1: capture rd_data from DAT_I. Clear CYC_O, STB_O and WE_O. Go to RESP.
  - Load extraction: shift DAT_I right by 8 * addr[2:0], keep the low 8·2^size bits, then sign- or zero-extend; size 3 returns the full word.
  - Timeout: the counter increments on each WAIT edge with ACK_I = 0. When it reaches TIMEOUT_CYCLES: clear CYC_O/STB_O, set bus_error = 1, leave rd_data unchanged, go to RESP.
  - ACK_I and the timeout on the same edge: ACK wins.
  - ACK_I outside WAIT is ignored.
- RESP:
  - Lasts exactly one cycle: done = 1, busy = 0. The misaligned/bus_error flags are valid in this cycle.
  - Next state is IDLE. Requests present during RESP are ignored; the next request is accepted the cycle after.
  - The timeout counter is cleared here.
- Latency: request edge to done is at least 2 cycles (ACK in the first WAIT cycle). A misaligned request completes in 1 cycle.
- One outstanding transaction only. rd_en/wr_en while busy are ignored, and the core must hold them until done.

Test Plan:
- Aligned load: size=3 at 0x0100_0008, responder ACKs 3 cycles later with 0x1122334455667788 → ADR_O=0x0100_0008, SEL_O=0xFF, WE_O=0, rd_data=0x1122334455667788 with done, CYC_O low the cycle after ACK.
- Signed byte load: addr 0x0100_0005, DAT_I=0x0000_8000_0000_0000, unsigned_load=0 → SEL_O=0x20, rd_data=0xFFFF_FFFF_FFFF_FF80. Same with unsigned_load=1 → 0x80.
- Half store: addr 0x0100_0006, wr_data=0xABCD → SEL_O=0xC0, DAT_O[63:48]=0xABCD, WE_O=1, done one cycle after ACK.
- Misaligned: word load at 0x0100_0002 → CYC_O stays 0; done and misaligned high for exactly one cycle, one cycle after the request.
- Timeout: TIMEOUT_CYCLES=4, ACK_I held low → CYC_O drops after 4 wait cycles, bus_error and done pulse together, rd_data unchanged. Repeat with ACK on the 4th edge → normal completion, bus_error=0.
- Reset mid-WAIT: assert RST_I between edges → CYC_O, busy=0 immediately. A later ACK_I pulse produces no done. A new request after reset completes normally.
